// File: rtl/hs_req_sender.sv
// hs_req_sender: initiator side of a 4-phase req/ack handshake.
// A local valid/ready word is launched as registered tx_req/tx_data toward a
// foreign clock domain. The returning tx_ack is brought in through a
// SYNC_STAGES-deep synchronizer, and only its last stage (ack_s) steers the FSM.
// Optional ack timeout is built when HS_TIMEOUT_EN is defined.
module hs_req_sender #(
    parameter int DATA_W         = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ack,
    output logic              done,
    output logic              busy,
    output logic              err
);

    // Reject configurations the synchronizer and timeout logic cannot honour
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("hs_req_sender: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    // Synchronizer chain for the asynchronous acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_sync <= '0;
        else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], tx_ack};
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // A stale-high ack from a previous transfer must drain before a new accept
    assign in_ready = (state == IDLE) && !ack_s;
    assign busy     = (state != IDLE);

`ifdef HS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            aborted;  // current transfer was abandoned; suppress done
    logic            err_r;

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Handshake FSM; done/err are single-cycle registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_req  <= 1'b0;
            tx_data <= '0;
            done    <= 1'b0;
`ifdef HS_TIMEOUT_EN
            to_cnt  <= '0;
            aborted <= 1'b0;
            err_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef HS_TIMEOUT_EN
            err_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        tx_data <= in_data;
                        tx_req  <= 1'b1;
                        state   <= REQ_HI;
`ifdef HS_TIMEOUT_EN
                        to_cnt  <= '0;
                        aborted <= 1'b0;
`endif
                    end
                end
                REQ_HI: begin
                    // An ack arriving on the limit edge still completes normally
                    if (ack_s) begin
                        tx_req <= 1'b0;
                        state  <= REQ_LO;
                    end
`ifdef HS_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        tx_req  <= 1'b0;
                        err_r   <= 1'b1;
                        aborted <= 1'b1;
                        state   <= REQ_LO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                REQ_LO: begin
                    // Wait for the foreign side to release ack before closing
                    if (!ack_s) begin
                        state <= IDLE;
`ifdef HS_TIMEOUT_EN
                        done    <= !aborted;
                        aborted <= 1'b0;
`else
                        done  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_req_sender.sv
// Self-checking bench for hs_req_sender (DATA_W=8, SYNC_STAGES=2).
// Inputs are driven on the falling edge; outputs are sampled there too.
// Accepted words go into a scoreboard queue and are checked on each done.
module tb_hs_req_sender;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack = 1'b0;
    logic       done;
    logic       busy;
    logic       err;

    int errs = 0;
    int checks = 0;

    logic [7:0] q_exp[$];    // scoreboard: words accepted, awaiting done
    logic [7:0] offer_q[$];  // words the source still wants to send
    bit         acc_pending = 0;
    bit         accepted = 0;
    bit         auto_ack = 0;
    int         hi_cnt = 0;
    int         lo_cnt = 0;

    always #5 clk = ~clk;

    hs_req_sender #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_req(tx_req), .tx_data(tx_data),
        .tx_ack(tx_ack), .done(done), .busy(busy), .err(err)
    );

    // One cycle: foreign responder model (ack 3 cycles after req edges) and
    // the valid/ready source that holds in_valid until accepted.
    task automatic tick();
        @(negedge clk);
        if (auto_ack) begin
            if (tx_req) begin
                lo_cnt = 0; hi_cnt++;
                if (hi_cnt >= 3) tx_ack = 1'b1;
            end else if (tx_ack) begin
                hi_cnt = 0; lo_cnt++;
                if (lo_cnt >= 3) begin tx_ack = 1'b0; lo_cnt = 0; end
            end else begin
                hi_cnt = 0; lo_cnt = 0;
            end
        end
        accepted = 0;
        if (acc_pending) begin void'(offer_q.pop_front()); acc_pending = 0; end
        if (offer_q.size() > 0) begin in_valid = 1'b1; in_data = offer_q[0]; end
        else in_valid = 1'b0;
        if (in_valid && in_ready) begin
            q_exp.push_back(in_data);
            acc_pending = 1; accepted = 1;
        end
    endtask

    task automatic clear_bench();
        q_exp.delete(); offer_q.delete();
        acc_pending = 0; auto_ack = 0; tx_ack = 1'b0; in_valid = 1'b0;
        hi_cnt = 0; lo_cnt = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({tx_req, tx_data, done, busy, err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL reset_state: got req=%b data=%h done=%b busy=%b err=%b rdy=%b, want 0 00 0 0 0 1",
                     tx_req, tx_data, done, busy, err, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_xfer();
        int budget;
        offer_q.push_back(8'h3C);
        budget = 0;
        do begin tick(); budget++; end while (!tx_req && budget < 20);
        tick(); tick();
        checks++;
        if (!(tx_req && busy)) begin errs++; $display("FAIL midrst_setup: req=%b busy=%b want 1 1", tx_req, busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_req, busy, done} !== 3'b000) begin
            errs++; $display("FAIL midrst_async: req/busy/done=%b want 000", {tx_req, busy, done});
        end
        @(negedge clk);
        clear_bench();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        int t, t_acc, t_done, req_hi, ndone;
        logic [7:0] exp;
        auto_ack = 1;
        offer_q.push_back(8'hA5);
        t = 0; t_acc = -1; t_done = -1; req_hi = 0; ndone = 0;
        while (t < 40) begin
            tick();
            if (accepted) t_acc = t;
            if (tx_req) req_hi++;
            if (busy) begin
                checks++;
                if (tx_data !== 8'hA5) begin errs++; $display("FAIL single_stable: got %h want a5", tx_data); end
            end
            if (err) begin errs++; checks++; $display("FAIL single_err: got 1 want 0"); end
            if (done) begin
                ndone++; t_done = t;
                exp = q_exp.pop_front();
                checks++;
                if (tx_data !== exp) begin errs++; $display("FAIL single_data: got %h want %h", tx_data, exp); end
            end
            t++;
        end
        checks++;
        if (ndone != 1) begin errs++; $display("FAIL single_done_count: got %0d want 1", ndone); end
        checks++;
        if (t_done - t_acc != 11) begin errs++; $display("FAIL single_latency: got %0d want 11", t_done - t_acc); end
        checks++;
        if (req_hi != 5) begin errs++; $display("FAIL single_req_width: got %0d want 5", req_hi); end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errs++; $display("FAIL single_idle_after: busy=%b rdy=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int t, nacc, ndone;
        logic [7:0] exp;
        logic [7:0] order[2];
        auto_ack = 1;
        offer_q.push_back(8'h11);
        offer_q.push_back(8'h22);
        t = 0; nacc = 0; ndone = 0;
        while (ndone < 2 && t < 80) begin
            tick();
            if (done) begin
                exp = q_exp.pop_front();
                checks++;
                if (tx_data !== exp) begin errs++; $display("FAIL b2b_data: got %h want %h", tx_data, exp); end
                if (ndone < 2) order[ndone] = tx_data;
                ndone++;
            end
            if (accepted) begin
                nacc++;
                checks++;
                if (ndone < nacc - 1) begin
                    errs++; $display("FAIL b2b_early_accept: accept %0d with %0d done", nacc, ndone);
                end
            end
            t++;
        end
        checks++;
        if (ndone != 2) begin errs++; $display("FAIL b2b_done_count: got %0d want 2 (budget)", ndone); end
        checks++;
        if (order[0] !== 8'h11 || order[1] !== 8'h22) begin
            errs++; $display("FAIL b2b_order: got %h %h want 11 22", order[0], order[1]);
        end
        auto_ack = 0;
    endtask

    task automatic test_stale_ack();
        int t, ndone;
        logic [7:0] exp;
        tx_ack = 1'b1;
        tick(); tick(); tick();
        offer_q.push_back(8'h77);
        repeat (4) tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || q_exp.size() != 0) begin
            errs++; $display("FAIL stale_blocked: rdy=%b busy=%b acc=%0d want 0 0 0", in_ready, busy, q_exp.size());
        end
        tx_ack = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL stale_drain1: rdy=%b want 0", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b1 || !accepted) begin
            errs++; $display("FAIL stale_drain2: rdy=%b acc=%b want 1 1", in_ready, accepted);
        end
        auto_ack = 1;
        t = 0; ndone = 0;
        while (ndone < 1 && t < 40) begin
            tick();
            if (done) begin
                ndone++;
                exp = q_exp.pop_front();
                checks++;
                if (tx_data !== exp) begin errs++; $display("FAIL stale_data: got %h want %h", tx_data, exp); end
            end
            t++;
        end
        checks++;
        if (ndone != 1) begin errs++; $display("FAIL stale_done: got %0d want 1 (budget)", ndone); end
        auto_ack = 0;
    endtask

    task automatic test_glitch();
        int budget, ndone;
        bit seen_lo;
        logic [7:0] exp;
        offer_q.push_back(8'h5A);
        budget = 0;
        do begin tick(); budget++; end while (!tx_req && budget < 20);
        // Sub-cycle pulse between edges: must be invisible
        tx_ack = 1'b1; #2; tx_ack = 1'b0;
        repeat (5) tick();
        checks++;
        if (tx_req !== 1'b1 || busy !== 1'b1) begin
            errs++; $display("FAIL glitch_short: req=%b busy=%b want 1 1", tx_req, busy);
        end
        // Clock-aligned one-cycle pulse: sampled once, full handshake
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        ndone = 0; seen_lo = 0;
        repeat (15) begin
            tick();
            if (!tx_req && busy) seen_lo = 1;
            if (done) begin
                ndone++;
                exp = q_exp.pop_front();
                checks++;
                if (tx_data !== exp) begin errs++; $display("FAIL glitch_data: got %h want %h", tx_data, exp); end
            end
        end
        checks++;
        if (ndone != 1) begin errs++; $display("FAIL glitch_done_count: got %0d want 1", ndone); end
        checks++;
        if (!seen_lo) begin errs++; $display("FAIL glitch_req_lo: REQ_LO seen=%b want 1", seen_lo); end
    endtask

`ifdef HS_TIMEOUT_EN
    task automatic test_timeout();
        int t, t_acc, req_hi, nerr, ndone, t_err, t_rdy;
        offer_q.push_back(8'hC3);
        t = 0; t_acc = -1; req_hi = 0; nerr = 0; ndone = 0; t_err = -1; t_rdy = -1;
        while (t < 30) begin
            tick();
            if (accepted) t_acc = t;
            if (t_acc >= 0 && t > t_acc) begin
                if (tx_req) req_hi++;
                if (err) begin nerr++; t_err = t - t_acc; end
                if (done) ndone++;
                if (in_ready && t_rdy < 0) t_rdy = t - t_acc;
            end
            t++;
        end
        checks++;
        if (req_hi != 8) begin errs++; $display("FAIL to_req_width: got %0d want 8", req_hi); end
        checks++;
        if (nerr != 1 || t_err != 9) begin errs++; $display("FAIL to_err: count=%0d at=%0d want 1 at 9", nerr, t_err); end
        checks++;
        if (ndone != 0) begin errs++; $display("FAIL to_done: got %0d want 0", ndone); end
        checks++;
        if (t_rdy != 10) begin errs++; $display("FAIL to_ready: at %0d want 10", t_rdy); end
        q_exp.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_xfer();
        test_single();
        test_back_to_back();
        test_stale_ack();
        test_glitch();
`ifdef HS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
